// File: rtl/udp_arb_pkg.sv
// Shared types and constants for the two-channel UDP transmit arbiter.
package udp_arb_pkg;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 20;
  localparam int BYTE_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} arb_state_t;
endpackage

// File: rtl/udp_arb_req_latch.sv
// Per-channel request latch: pending flag, byte-count capture and the
// immediate done pulse for zero-length requests that never reach the engine.
module udp_arb_req_latch
  import udp_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_en,
  input  logic [BYTE_W-1:0] i_byte_num,
  input  logic              i_take,
  output logic              o_pending,
  output logic [BYTE_W-1:0] o_byte_num,
  output logic              o_zero_done
);

  logic              r_pending;
  logic [BYTE_W-1:0] r_byte_num;
  logic              r_zero_done;
  logic              w_nonzero_start;

  assign w_nonzero_start = i_start_en && (i_byte_num != '0);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending   <= 1'b0;
      r_byte_num  <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= i_start_en && (i_byte_num == '0);
      // A fresh request arriving on the grant cycle re-arms the channel.
      if (w_nonzero_start && (!r_pending || i_take)) begin
        r_pending  <= 1'b1;
        r_byte_num <= i_byte_num;
      end else if (i_take) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_pending   = r_pending;
  assign o_byte_num  = r_byte_num;
  assign o_zero_done = r_zero_done;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP TX engine between the image packetizer
// (ch0) and the command/status responder (ch1), with gap and timeout control.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter logic [15:0]      GAP_CYCLES     = 16'd800,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic              eth_tx_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              ch0_tx_start_en,
  input  logic [BYTE_W-1:0] ch0_tx_byte_num,
  input  logic [DATA_W-1:0] ch0_tx_data,
  output logic              ch0_tx_req,
  output logic              ch0_tx_done,
  input  logic              ch1_tx_start_en,
  input  logic [BYTE_W-1:0] ch1_tx_byte_num,
  input  logic [DATA_W-1:0] ch1_tx_data,
  output logic              ch1_tx_req,
  output logic              ch1_tx_done,
  output logic              udp_tx_start_en,
  output logic [BYTE_W-1:0] udp_tx_byte_num,
  output logic [DATA_W-1:0] udp_tx_data,
  input  logic              udp_tx_req,
  input  logic              udp_tx_done,
  output logic [1:0]        grant,
  output logic              tx_timeout
);

  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES == 16'd0) ? '0 : CNT_W'(GAP_CYCLES) - CNT_W'(1);

  logic [NUM_CH-1:0]             w_start_en, w_pending, w_take, w_zero_done, w_sel;
  logic [NUM_CH-1:0][BYTE_W-1:0] w_byte_in, w_count;
  arb_state_t                    r_state, w_next;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_CH-1:0]             r_grant, r_eng_done;
  logic                          r_last;
  logic [BYTE_W-1:0]             r_byte_num;
  logic                          w_timeout, w_in_send;

  assign w_start_en = {ch1_tx_start_en, ch0_tx_start_en};
  assign w_byte_in  = {ch1_tx_byte_num, ch0_tx_byte_num};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    udp_arb_req_latch u_req_latch (
      .i_clk       (eth_tx_clk),
      .i_rst       (rst),
      .i_start_en  (w_start_en[g]),
      .i_byte_num  (w_byte_in[g]),
      .i_take      (w_take[g]),
      .o_pending   (w_pending[g]),
      .o_byte_num  (w_count[g]),
      .o_zero_done (w_zero_done[g])
    );
  end

  // r_last names the channel granted most recently; ties go to the other one.
  always_comb begin
    w_sel = w_pending;
    if (w_pending == 2'b11) w_sel = r_last ? 2'b01 : 2'b10;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:  if (enable && (|w_pending)) w_next = START;
      START: w_next = SEND;
      SEND: begin
        if (udp_tx_done) begin
          w_next = GAP;
        end else if (r_cnt == TIMEOUT_CYCLES) begin
          w_timeout = 1'b1;
          w_next    = GAP;
        end
      end
      GAP:     if (r_cnt == GAP_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_take = ((r_state == IDLE) && (w_next == START)) ? w_sel : '0;

  always_ff @(posedge eth_tx_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_last     <= 1'b1;
      r_byte_num <= '0;
      r_eng_done <= '0;
    end else begin
      r_state    <= w_next;
      r_eng_done <= '0;
      if (w_next != r_state)    r_cnt <= '0;
      else if (r_state != IDLE) r_cnt <= r_cnt + CNT_W'(1);
      if (|w_take) begin
        r_grant    <= w_take;
        r_last     <= w_take[1];
        r_byte_num <= w_take[1] ? w_count[1] : w_count[0];
      end
      if ((r_state == SEND) && (w_next == GAP)) begin
        r_grant <= '0;
        if (udp_tx_done) r_eng_done <= r_grant;
      end
    end
  end

  assign w_in_send = (r_state == SEND);

  always_comb begin
    udp_tx_data = '0;
    if (w_in_send) begin
      if (r_grant[0])      udp_tx_data = ch0_tx_data;
      else if (r_grant[1]) udp_tx_data = ch1_tx_data;
    end
  end

  assign ch0_tx_req      = w_in_send & r_grant[0] & udp_tx_req;
  assign ch1_tx_req      = w_in_send & r_grant[1] & udp_tx_req;
  assign ch0_tx_done     = r_eng_done[0] | w_zero_done[0];
  assign ch1_tx_done     = r_eng_done[1] | w_zero_done[1];
  assign udp_tx_start_en = (r_state == START);
  assign udp_tx_byte_num = r_byte_num;
  assign grant           = r_grant;
  assign tx_timeout      = w_timeout;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: expected engine starts are queued when
// stimulus is driven and compared when udp_tx_start_en is observed.
module tb_udp_tx_arbiter;
  localparam int GAP = 800;
  localparam int TMO = 1000;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic        ch0_tx_start_en = 1'b0, ch1_tx_start_en = 1'b0;
  logic [15:0] ch0_tx_byte_num = '0, ch1_tx_byte_num = '0;
  logic [31:0] ch0_tx_data = '0, ch1_tx_data = '0;
  logic        ch0_tx_req, ch0_tx_done, ch1_tx_req, ch1_tx_done;
  logic        udp_tx_start_en, udp_tx_req = 1'b0, udp_tx_done = 1'b0;
  logic [15:0] udp_tx_byte_num;
  logic [31:0] udp_tx_data;
  logic [1:0]  grant;
  logic        tx_timeout;

  typedef struct {
    logic [1:0]  grant;
    logic [15:0] bytes;
    int          at;      // exact start cycle, 0 = not fixed
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, start_cyc = 0, end_cyc = 0, to_cyc = 0;
  int   n_starts = 0, n_done0 = 0, n_done1 = 0, n_timeouts = 0;
  bit   have_end = 1'b0;

  udp_tx_arbiter #(.GAP_CYCLES(16'd800), .TIMEOUT_CYCLES(20'd1000)) dut (
    .eth_tx_clk      (clk),
    .rst             (rst),
    .enable          (enable),
    .ch0_tx_start_en (ch0_tx_start_en),
    .ch0_tx_byte_num (ch0_tx_byte_num),
    .ch0_tx_data     (ch0_tx_data),
    .ch0_tx_req      (ch0_tx_req),
    .ch0_tx_done     (ch0_tx_done),
    .ch1_tx_start_en (ch1_tx_start_en),
    .ch1_tx_byte_num (ch1_tx_byte_num),
    .ch1_tx_data     (ch1_tx_data),
    .ch1_tx_req      (ch1_tx_req),
    .ch1_tx_done     (ch1_tx_done),
    .udp_tx_start_en (udp_tx_start_en),
    .udp_tx_byte_num (udp_tx_byte_num),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_req      (udp_tx_req),
    .udp_tx_done     (udp_tx_done),
    .grant           (grant),
    .tx_timeout      (tx_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Output monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (udp_tx_start_en) begin
        n_starts++;
        start_cyc = cyc;
        check("sb_empty_at_start", 32'(sb.size() == 0), 32'd0);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("start_grant", 32'(grant), 32'(mon_e.grant));
          check("start_byte_num", 32'(udp_tx_byte_num), 32'(mon_e.bytes));
          if (mon_e.at != 0) check("start_cycle", cyc, mon_e.at);
        end
        if (have_end) check("gap_respected", 32'(cyc >= end_cyc + GAP + 2), 32'd1);
      end
      if (ch0_tx_done) n_done0++;
      if (ch1_tx_done) n_done1++;
      if (tx_timeout) begin
        n_timeouts++;
        to_cyc   = cyc;
        end_cyc  = cyc;
        have_end = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch, input logic [15:0] n);
    if (ch == 0) begin ch0_tx_start_en = 1'b1; ch0_tx_byte_num = n; end
    else         begin ch1_tx_start_en = 1'b1; ch1_tx_byte_num = n; end
    tick();
    ch0_tx_start_en = 1'b0;
    ch1_tx_start_en = 1'b0;
  endtask

  task automatic push(input logic [1:0] g, input logic [15:0] n, input int at);
    exp_t e;
    e.grant = g; e.bytes = n; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n0 = n_starts;
    int i  = 0;
    while (n_starts == n0 && i < budget) begin tick(); i++; end
    check({tag, "_start_seen"}, 32'(n_starts != n0), 32'd1);
  endtask

  task automatic finish_pkt(input int dly);
    while (cyc < start_cyc + dly) tick();
    udp_tx_done = 1'b1;
    end_cyc     = cyc;
    have_end    = 1'b1;
    tick();
    udp_tx_done = 1'b0;
  endtask

  task automatic serve(input string tag, input int dly);
    wait_start(tag, 2 * GAP + TMO);
    finish_pkt(dly);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    have_end = 1'b0;
  endtask

  initial begin
    int d0, d1, t0, s0;

    // Reset state
    tick(); tick(); tick();
    check("rst_start_en", 32'(udp_tx_start_en), 32'd0);
    check("rst_byte_num", 32'(udp_tx_byte_num), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_data", udp_tx_data, 32'd0);
    check("rst_dones", 32'({ch1_tx_done, ch0_tx_done, tx_timeout}), 32'd0);
    rst = 1'b0;
    tick();

    // Single ch0 packet, done 300 cycles after start
    push(2'b01, 16'd964, cyc + 2);
    pulse(0, 16'd964);
    wait_start("t1", 10);
    udp_tx_req = 1'b1; ch0_tx_data = 32'hA5A5_0001; ch1_tx_data = 32'h5A5A_0002;
    #1;
    check("t1_ch0_req", 32'(ch0_tx_req), 32'd1);
    check("t1_ch1_req", 32'(ch1_tx_req), 32'd0);
    check("t1_data", udp_tx_data, 32'hA5A5_0001);
    check("t1_grant", 32'(grant), 32'd1);
    finish_pkt(300);
    check("t1_ch0_done", 32'(ch0_tx_done), 32'd1);
    check("t1_ch1_done", 32'(ch1_tx_done), 32'd0);
    check("t1_gap_grant", 32'(grant), 32'd0);
    check("t1_gap_data", udp_tx_data, 32'd0);
    check("t1_gap_req", 32'(ch0_tx_req), 32'd0);
    udp_tx_req = 1'b0;

    // ch1 arrives during a ch0 SEND and is served right after the gap
    push(2'b01, 16'd500, end_cyc + GAP + 2);
    pulse(0, 16'd500);
    check("t1_done_one_cycle", 32'(ch0_tx_done), 32'd0);
    wait_start("t3a", 2 * GAP);
    pulse(1, 16'd64);
    finish_pkt(30);
    push(2'b10, 16'd64, end_cyc + GAP + 2);
    wait_start("t3b", 2 * GAP);
    udp_tx_req = 1'b1; ch0_tx_data = 32'h1111_1111; ch1_tx_data = 32'h2222_2222;
    #1;
    check("t3_data_ch1", udp_tx_data, 32'h2222_2222);
    check("t3_ch0_req", 32'(ch0_tx_req), 32'd0);
    check("t3_ch1_req", 32'(ch1_tx_req), 32'd1);
    ch1_tx_data = 32'h3333_0000 | 32'($urandom_range(0, 65535));
    #1;
    check("t3_data_track", udp_tx_data, ch1_tx_data);
    udp_tx_req = 1'b0;
    finish_pkt(30);

    // Engine never finishes: timeout, then pending ch1 is served
    push(2'b01, 16'd300, end_cyc + GAP + 2);
    pulse(0, 16'd300);
    wait_start("t4a", 2 * GAP);
    d0 = n_done0; d1 = n_done1; t0 = n_timeouts;
    pulse(1, 16'd77);
    for (int i = 0; i < TMO + 200 && n_timeouts == t0; i++) tick();
    check("t4_timeout_seen", 32'(n_timeouts != t0), 32'd1);
    check("t4_timeout_cycle", to_cyc, start_cyc + 1 + TMO);
    push(2'b10, 16'd77, to_cyc + GAP + 2);
    serve("t4b", 30);
    check("t4_no_ch0_done", n_done0, d0);
    check("t4_timeout_once", n_timeouts, t0 + 1);
    tick();
    check("t4_ch1_done", n_done1, d1 + 1);

    // Simultaneous requests alternate 01,10 from a fresh reset
    do_reset();
    for (int r = 0; r < 4; r++) begin
      ch0_tx_start_en = 1'b1; ch0_tx_byte_num = 16'(100 + r);
      ch1_tx_start_en = 1'b1; ch1_tx_byte_num = 16'(200 + r);
      push(2'b01, 16'(100 + r), (r == 0) ? cyc + 2 : 0);
      push(2'b10, 16'(200 + r), 0);
      tick();
      ch0_tx_start_en = 1'b0; ch1_tx_start_en = 1'b0;
      serve("rr_a", 20);
      serve("rr_b", 20);
    end
    repeat (GAP + 20) tick();

    // Zero-length request and stray engine done while idle
    d0 = n_done0; d1 = n_done1; s0 = n_starts;
    pulse(1, 16'd0);
    check("t5_zero_done", 32'(ch1_tx_done), 32'd1);
    tick();
    check("t5_zero_done_once", 32'(ch1_tx_done), 32'd0);
    udp_tx_done = 1'b1;
    tick();
    udp_tx_done = 1'b0;
    repeat (5) tick();
    check("t5_no_start", n_starts, s0);
    check("t5_ch1_done_count", n_done1, d1 + 1);
    check("t5_ch0_done_count", n_done0, d0);

    // enable low holds a pending request; duplicate pulse keeps first count
    enable = 1'b0;
    pulse(0, 16'd100);
    tick(); tick();
    pulse(0, 16'd200);
    repeat (20) tick();
    check("t6_blocked", n_starts, s0);
    check("t6_grant_idle", 32'(grant), 32'd0);
    enable = 1'b1;
    push(2'b01, 16'd100, cyc + 1);
    serve("t6", 20);
    repeat (GAP + 20) tick();

    // Reset in the middle of SEND
    push(2'b01, 16'd50, cyc + 2);
    pulse(0, 16'd50);
    wait_start("t7", 10);
    udp_tx_req = 1'b1; ch0_tx_data = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    d0 = n_done0; d1 = n_done1; s0 = n_starts; t0 = n_timeouts;
    rst = 1'b1;
    #1;
    check("t7_start_en", 32'(udp_tx_start_en), 32'd0);
    check("t7_byte_num", 32'(udp_tx_byte_num), 32'd0);
    check("t7_grant", 32'(grant), 32'd0);
    check("t7_reqs", 32'({ch1_tx_req, ch0_tx_req}), 32'd0);
    check("t7_data", udp_tx_data, 32'd0);
    check("t7_pulses", 32'({ch1_tx_done, ch0_tx_done, tx_timeout}), 32'd0);
    tick(); tick();
    rst = 1'b0; have_end = 1'b0; udp_tx_req = 1'b0;
    repeat (10) tick();
    check("t7_no_restart", n_starts, s0);
    check("t7_no_done", n_done0 + n_done1, d0 + d1);
    check("t7_no_timeout", n_timeouts, t0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
